act_mac_unit: RTL and testbench

ACT_MAC_UNIT -- requirements
Module: act_mac_unit

---
 rtl/act_mac_unit.sv | 256 +++++++++++++++++++++++++
 tb/tb_act_mac_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_mac_unit.sv
// ---------------------------------------------------------------------------
// act_mac_unit
//
// Purpose: signed dot-product engine for one output neuron. Activations
// stream in from the input activation controller and are multiplied against
// an internal weight buffer. The accumulated sum gets a bias added, is
// requantized by an arithmetic right shift, optionally passed through ReLU,
// and is clamped to a signed 8-bit result.
//
// Ports:
//   CLK, RESETN          single clock, asynchronous active-low reset
//   START                control-register level; a rising edge in IDLE
//                        starts one dot product
//   NUM_ELEMS            element count N (clamped to WEIGHT_DEPTH)
//   BIAS, SHIFT, RELU_EN requantization controls, sampled at start
//   WEIGHT_WR_*          weight buffer write port (usable in any state)
//   ACT_DATA/ACT_VALID   activation stream from the controller
//   RESULT/RESULT_VALID  quantized result and its one-cycle update strobe
//   BUSY                 operation in progress
//   DONE, ACC_OVERFLOW   sticky completion and saturation flags
// ---------------------------------------------------------------------------
module act_mac_unit #(
    parameter int ACT_WIDTH    = 8,
    parameter int WEIGHT_DEPTH = 64,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                            CLK,
    input  logic                            RESETN,
    input  logic                            START,
    input  logic [$clog2(WEIGHT_DEPTH):0]   NUM_ELEMS,
    input  logic [ACC_WIDTH-1:0]            BIAS,
    input  logic [4:0]                      SHIFT,
    input  logic                            RELU_EN,
    input  logic                            WEIGHT_WR_CMD,
    input  logic [$clog2(WEIGHT_DEPTH)-1:0] WEIGHT_WR_ADDR,
    input  logic [7:0]                      WEIGHT_WR_DATA,
    input  logic [ACT_WIDTH-1:0]            ACT_DATA,
    input  logic                            ACT_VALID,
    output logic [7:0]                      RESULT,
    output logic                            RESULT_VALID,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            ACC_OVERFLOW
);

    localparam int AW = $clog2(WEIGHT_DEPTH);
    localparam int NW = AW + 1;
    localparam int PW = ACT_WIDTH + 8;
    localparam int SW = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_QUANT = 2'd3
    } state_e;

    // Saturating signed add. Bit [ACC_WIDTH] of the return value flags that
    // the true sum fell outside the accumulator range and was clamped.
    function automatic logic [ACC_WIDTH:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [SW-1:0] sum;
        sum = SW'(a) + SW'(b);
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            if (sum[ACC_WIDTH]) begin
                sat_add = {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                sat_add = {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            sat_add = {1'b0, sum[ACC_WIDTH-1:0]};
        end
    endfunction

    // Optional ReLU followed by a clamp to [-128, 127]. A value fits in
    // int8 exactly when every bit from bit 7 upward equals the sign bit.
    function automatic logic [7:0] quant8(
        input logic signed [ACC_WIDTH-1:0] v,
        input logic                        relu
    );
        logic [ACC_WIDTH-8:0] upper;
        upper = v[ACC_WIDTH-1:7];
        if (v[ACC_WIDTH-1]) begin
            if (relu) begin
                quant8 = 8'h00;
            end else if (&upper) begin
                quant8 = v[7:0];
            end else begin
                quant8 = 8'h80;
            end
        end else if (|upper) begin
            quant8 = 8'h7F;
        end else begin
            quant8 = v[7:0];
        end
    endfunction

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [AW-1:0]               idx_q, idx_d;
    logic [NW-1:0]               n_q, n_d;
    logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
    logic [4:0]                  shift_q, shift_d;
    logic                        relu_q, relu_d;
    logic                        start_prev_q, start_prev_d;
    logic [7:0]                  result_q, result_d;
    logic                        result_valid_q, result_valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        ovf_q, ovf_d;

    logic [7:0]                  weight_mem_q [WEIGHT_DEPTH];

    logic                        start_pulse_s;
    logic [NW-1:0]               n_clamped_s;
    logic                        last_s;
    logic [7:0]                  weight_s;
    logic signed [PW-1:0]        act_ext_s;
    logic signed [PW-1:0]        wt_ext_s;
    logic signed [PW-1:0]        prod_s;
    logic signed [ACC_WIDTH-1:0] prod_acc_s;
    logic [ACC_WIDTH:0]          mac_sum_s;
    logic [ACC_WIDTH:0]          bias_sum_s;
    logic signed [ACC_WIDTH-1:0] shifted_s;

    assign start_pulse_s = START & ~start_prev_q;
    assign n_clamped_s   = (NUM_ELEMS > NW'(WEIGHT_DEPTH)) ? NW'(WEIGHT_DEPTH) : NUM_ELEMS;
    assign last_s        = ({1'b0, idx_q} == (n_q - NW'(1)));

    // Combinational read: a same-cycle write lands on the edge, so the
    // element accepted on that edge still sees the old weight.
    assign weight_s   = weight_mem_q[idx_q];
    assign act_ext_s  = PW'($signed(ACT_DATA));
    assign wt_ext_s   = PW'($signed(weight_s));
    assign prod_s     = act_ext_s * wt_ext_s;
    assign prod_acc_s = ACC_WIDTH'(prod_s);
    assign mac_sum_s  = sat_add(acc_q, prod_acc_s);
    assign bias_sum_s = sat_add(acc_q, bias_q);
    assign shifted_s  = acc_q >>> shift_q;

    // Weight buffer write port; deliberately outside the reset domain so
    // weights survive RESETN.
    always_ff @(posedge CLK) begin
        if (WEIGHT_WR_CMD) begin
            weight_mem_q[WEIGHT_WR_ADDR] <= WEIGHT_WR_DATA;
        end
    end

    // Next-state and datapath logic for the IDLE/ACCUM/BIAS/QUANT sequence.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        idx_d          = idx_q;
        n_d            = n_q;
        bias_d         = bias_q;
        shift_d        = shift_q;
        relu_d         = relu_q;
        done_d         = done_q;
        ovf_d          = ovf_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        start_prev_d   = START;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse_s) begin
                    acc_d   = {ACC_WIDTH{1'b0}};
                    idx_d   = {AW{1'b0}};
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    n_d     = n_clamped_s;
                    bias_d  = BIAS;
                    shift_d = SHIFT;
                    relu_d  = RELU_EN;
                    if (n_clamped_s != {NW{1'b0}}) begin
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_BIAS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (ACT_VALID) begin
                    acc_d = mac_sum_s[ACC_WIDTH-1:0];
                    ovf_d = ovf_q | mac_sum_s[ACC_WIDTH];
                    idx_d = idx_q + AW'(1);
                    if (last_s) begin
                        state_d = ST_BIAS;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_BIAS: begin
                acc_d   = bias_sum_s[ACC_WIDTH-1:0];
                ovf_d   = ovf_q | bias_sum_s[ACC_WIDTH];
                state_d = ST_QUANT;
            end
            ST_QUANT: begin
                result_d       = quant8(shifted_s, relu_q);
                result_valid_d = 1'b1;
                done_d         = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; RESETN aborts any operation in flight.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q        <= ST_IDLE;
            acc_q          <= {ACC_WIDTH{1'b0}};
            idx_q          <= {AW{1'b0}};
            n_q            <= {NW{1'b0}};
            bias_q         <= {ACC_WIDTH{1'b0}};
            shift_q        <= 5'd0;
            relu_q         <= 1'b0;
            start_prev_q   <= 1'b0;
            result_q       <= 8'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            n_q            <= n_d;
            bias_q         <= bias_d;
            shift_q        <= shift_d;
            relu_q         <= relu_d;
            start_prev_q   <= start_prev_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            ovf_q          <= ovf_d;
        end
    end

    assign RESULT       = result_q;
    assign RESULT_VALID = result_valid_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ACC_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_act_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_act_mac_unit
//
// Directed bench for act_mac_unit. Each operation's expected result, flag
// and completion cycle is computed from plain integer arithmetic and pushed
// to a scoreboard; one negedge process compares the DUT against it every
// cycle. Literal expectations after each operation pin the model.
// ---------------------------------------------------------------------------
module tb_act_mac_unit;

    localparam int WD = 8;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        START;
    logic [3:0]  NUM_ELEMS;
    logic [31:0] BIAS;
    logic [4:0]  SHIFT;
    logic        RELU_EN;
    logic        WEIGHT_WR_CMD;
    logic [2:0]  WEIGHT_WR_ADDR;
    logic [7:0]  WEIGHT_WR_DATA;
    logic [7:0]  ACT_DATA;
    logic        ACT_VALID;
    logic [7:0]  RESULT;
    logic        RESULT_VALID;
    logic        BUSY;
    logic        DONE;
    logic        ACC_OVERFLOW;

    act_mac_unit #(.ACT_WIDTH(8), .WEIGHT_DEPTH(WD), .ACC_WIDTH(32)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .NUM_ELEMS(NUM_ELEMS),
        .BIAS(BIAS), .SHIFT(SHIFT), .RELU_EN(RELU_EN),
        .WEIGHT_WR_CMD(WEIGHT_WR_CMD), .WEIGHT_WR_ADDR(WEIGHT_WR_ADDR),
        .WEIGHT_WR_DATA(WEIGHT_WR_DATA), .ACT_DATA(ACT_DATA),
        .ACT_VALID(ACT_VALID), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID),
        .BUSY(BUSY), .DONE(DONE), .ACC_OVERFLOW(ACC_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int     errors = 0;
    int     checks = 0;
    int     w_model [WD];
    int     act_vec [16];
    int     exp_res_q [$];
    int     exp_cyc_q [$];
    bit     exp_ovf_q [$];
    longint model_result = 0;
    int     sb_res;
    int     sb_cyc;
    bit     sb_ovf;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard compare: every cycle RESULT must equal the last expected
    // result; each RESULT_VALID must match a pending expectation in value,
    // completion cycle, overflow flag and DONE.
    always @(negedge CLK) begin
        if (!RESETN) model_result = 0;
        if (RESULT_VALID) begin
            if (exp_res_q.size() == 0) begin
                check("unexpected_valid", longint'(RESULT_VALID), 0);
            end else begin
                sb_res = exp_res_q.pop_front();
                sb_cyc = exp_cyc_q.pop_front();
                sb_ovf = exp_ovf_q.pop_front();
                model_result = sb_res;
                check("latency", cyc, sb_cyc);
                check("ovf_at_valid", longint'(ACC_OVERFLOW), longint'(sb_ovf));
                check("done_at_valid", longint'(DONE), 1);
            end
        end
        check("result", longint'($signed(RESULT)), model_result);
    end

    task automatic write_weight(input int a, input int d);
        WEIGHT_WR_CMD  = 1'b1;
        WEIGHT_WR_ADDR = 3'(a);
        WEIGHT_WR_DATA = 8'(d);
        tick();
        WEIGHT_WR_CMD = 1'b0;
        w_model[a] = d;
    endtask

    // One operation. gaps bit p gives ACT_VALID in drive slot p (valid
    // after slot 15). abort_at>0 pulls RESETN once that many elements are
    // accepted. wr_first rewrites weight 0 to 100 on the edge that
    // consumes element 0.
    task automatic run_op(input int n, input int bias, input int shift, input bit relu,
                          input logic [15:0] gaps, input int abort_at,
                          input bit wr_first, input bit valid_in_bias);
        int     ne;
        longint acc;
        longint maxv;
        longint minv;
        longint v;
        bit     ovf;
        int     idx;
        int     p;
        int     last;
        bit     vb;
        ne   = (n > WD) ? WD : n;
        maxv = 64'sd2147483647;
        minv = -maxv - 64'sd1;
        acc  = 0;
        ovf  = 1'b0;
        for (int i = 0; i < ne; i++) begin
            acc = acc + longint'(act_vec[i]) * longint'(w_model[i]);
            if (acc > maxv) begin acc = maxv; ovf = 1'b1; end
            else if (acc < minv) begin acc = minv; ovf = 1'b1; end
        end
        acc = acc + longint'(bias);
        if (acc > maxv) begin acc = maxv; ovf = 1'b1; end
        else if (acc < minv) begin acc = minv; ovf = 1'b1; end
        v = acc >>> shift;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;

        START = 1'b0;
        tick();
        NUM_ELEMS = 4'(n);
        BIAS      = 32'(bias);
        SHIFT     = 5'(shift);
        RELU_EN   = relu;
        START     = 1'b1;
        last      = cyc;
        tick();
        // Operands must have been captured; scramble the live inputs.
        NUM_ELEMS = 4'd1;
        BIAS      = 32'h0001_2345;
        SHIFT     = 5'd7;
        RELU_EN   = ~relu;
        START     = 1'b0;
        check("busy_after_start", longint'(BUSY), 1);
        check("done_cleared", longint'(DONE), 0);
        idx = 0;
        p   = 0;
        while (idx < ne) begin
            vb = (p < 16) ? gaps[p] : 1'b1;
            p++;
            ACT_VALID = vb;
            ACT_DATA  = vb ? 8'(act_vec[idx]) : 8'($urandom);
            START     = (p % 2 == 1);
            if (wr_first && idx == 0 && vb) begin
                WEIGHT_WR_CMD  = 1'b1;
                WEIGHT_WR_ADDR = 3'd0;
                WEIGHT_WR_DATA = 8'd100;
            end
            last = cyc;
            tick();
            WEIGHT_WR_CMD = 1'b0;
            if (vb) idx++;
            if (abort_at > 0 && idx == abort_at && vb) begin
                RESETN = 1'b0;
                #1;
                check("abort_busy", longint'(BUSY), 0);
                check("abort_valid", longint'(RESULT_VALID), 0);
                check("abort_result", longint'(RESULT), 0);
                tick();
                tick();
                RESETN    = 1'b1;
                ACT_VALID = 1'b0;
                START     = 1'b0;
                return;
            end
        end
        ACT_VALID = valid_in_bias;
        ACT_DATA  = 8'($urandom);
        START     = 1'b0;
        exp_res_q.push_back(int'(v));
        exp_cyc_q.push_back(last + 3);
        exp_ovf_q.push_back(ovf);
        if (wr_first) w_model[0] = 100;
        for (int k = 0; k < 12 && exp_res_q.size() != 0; k++) tick();
        if (exp_res_q.size() != 0) begin
            check("timeout_pending", exp_res_q.size(), 0);
            exp_res_q.delete();
            exp_cyc_q.delete();
            exp_ovf_q.delete();
        end
        ACT_VALID = 1'b0;
        tick();
        check("done_sticky", longint'(DONE), 1);
        check("busy_idle", longint'(BUSY), 0);
    endtask

    task automatic set_vecs(input int w0, input int w1, input int w2, input int w3,
                            input int a0, input int a1, input int a2, input int a3);
        write_weight(0, w0);
        write_weight(1, w1);
        write_weight(2, w2);
        write_weight(3, w3);
        act_vec[0] = a0;
        act_vec[1] = a1;
        act_vec[2] = a2;
        act_vec[3] = a3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESETN = 1'b0; START = 1'b0; NUM_ELEMS = 4'd0; BIAS = 32'd0;
        SHIFT = 5'd0; RELU_EN = 1'b0; WEIGHT_WR_CMD = 1'b0;
        WEIGHT_WR_ADDR = 3'd0; WEIGHT_WR_DATA = 8'd0; ACT_DATA = 8'd0;
        ACT_VALID = 1'b0;
        for (int i = 0; i < 16; i++) act_vec[i] = 0;
        for (int i = 0; i < WD; i++) w_model[i] = 0;
        tick();
        tick();
        check("rst_busy", longint'(BUSY), 0);
        check("rst_done", longint'(DONE), 0);
        check("rst_valid", longint'(RESULT_VALID), 0);
        check("rst_ovf", longint'(ACC_OVERFLOW), 0);
        check("rst_result", longint'(RESULT), 0);
        RESETN = 1'b1;
        tick();
        for (int i = 0; i < WD; i++) write_weight(i, 0);

        // Basic dot product, back to back.
        set_vecs(1, 2, 3, 4, 1, 1, 1, 1);
        run_op(4, 0, 0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_basic", longint'($signed(RESULT)), 10);
        check("lit_basic_ovf", longint'(ACC_OVERFLOW), 0);

        // Gapped valid 1 0 0 1 1 0 1.
        run_op(4, 0, 0, 1'b0, 16'h0059, 0, 1'b0, 1'b0);
        check("lit_gaps", longint'($signed(RESULT)), 10);

        // Negative result with and without ReLU.
        set_vecs(-5, -5, 0, 0, 10, 10, 0, 0);
        run_op(2, 0, 0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_neg", longint'($signed(RESULT)), -100);
        run_op(2, 0, 0, 1'b1, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_relu", longint'($signed(RESULT)), 0);

        // Output clamp, then bias plus shift.
        set_vecs(127, 127, 127, 127, 127, 127, 127, 127);
        run_op(4, 0, 0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_clamp", longint'($signed(RESULT)), 127);
        run_op(4, -64516 + 1000, 3, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_shift", longint'($signed(RESULT)), 125);

        // Accumulator saturation, then N=0 with valid held high.
        set_vecs(1, 0, 0, 0, 1, 0, 0, 0);
        run_op(1, 2147483647, 0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_sat", longint'($signed(RESULT)), 127);
        check("lit_sat_ovf", longint'(ACC_OVERFLOW), 1);
        run_op(0, -7, 0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b1);
        check("lit_n0", longint'($signed(RESULT)), -7);
        check("lit_n0_ovf", longint'(ACC_OVERFLOW), 0);

        // Write to the address being read returns the old weight.
        set_vecs(1, 2, 3, 4, 1, 1, 1, 1);
        run_op(4, 0, 0, 1'b0, 16'hFFFF, 0, 1'b1, 1'b0);
        check("lit_wr_old", longint'($signed(RESULT)), 10);
        run_op(4, 0, 0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_wr_new", longint'($signed(RESULT)), 109);

        // NUM_ELEMS above depth clamps to 8 elements: 1+2+...+8.
        for (int i = 0; i < WD; i++) write_weight(i, 1);
        for (int i = 0; i < 16; i++) act_vec[i] = i + 1;
        run_op(12, 0, 0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_nclamp", longint'($signed(RESULT)), 36);

        // Reset mid-ACCUM, then rerun with the weights intact.
        set_vecs(1, 2, 3, 4, 1, 1, 1, 1);
        run_op(4, 0, 0, 1'b0, 16'hFFFF, 2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("abort_no_done", longint'(DONE), 0);
        run_op(4, 0, 0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        check("lit_rerun", longint'($signed(RESULT)), 10);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
